// File: rtl/miriscv_decode_stage.sv
// miriscv_decode_stage: registered RV32I(+M) decoder with a 2-entry skid FIFO
// toward execute, pipeline flush and a saturating illegal-instruction counter.
module miriscv_decode_stage #(
  parameter bit M_EXT = 1'b0,
  parameter int CNT_W = 8,
  parameter int PC_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [31:0]       instr_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  output logic              dec_valid_o,
  input  logic              dec_ready_i,
  output logic [PC_W-1:0]   dec_pc_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [4:0]        rd_o,
  output logic [1:0]        ex_op_a_sel_o,
  output logic [2:0]        ex_op_b_sel_o,
  output logic [5:0]        alu_op_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [2:0]        mem_size_o,
  output logic              gpr_we_a_o,
  output logic              wb_src_sel_o,
  output logic              branch_o,
  output logic              jal_o,
  output logic              jalr_o,
  output logic              illegal_instr_o,
  output logic [CNT_W-1:0]  illegal_cnt_o
);

  // Major opcodes, instr[6:2]
  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  localparam logic [1:0] OP_A_RS1      = 2'd0;
  localparam logic [1:0] OP_A_CURR_PC  = 2'd1;
  localparam logic [1:0] OP_A_ZERO     = 2'd2;
  localparam logic [2:0] OP_B_RS2      = 3'd0;
  localparam logic [2:0] OP_B_IMM_I    = 3'd1;
  localparam logic [2:0] OP_B_IMM_U    = 3'd2;
  localparam logic [2:0] OP_B_IMM_S    = 3'd3;
  localparam logic [2:0] OP_B_INCR     = 3'd4;
  localparam logic [2:0] LDST_W        = 3'd2;
  localparam logic       WB_EX_RESULT  = 1'b0;
  localparam logic       WB_LSU_DATA   = 1'b1;

  // RV32I ALU codes widened by one bit; M ops live at {3'b100, funct3}
  localparam logic [5:0] ALU_ADD  = 6'b000000;
  localparam logic [5:0] ALU_SLL  = 6'b000001;
  localparam logic [5:0] ALU_SLTS = 6'b000010;
  localparam logic [5:0] ALU_SLTU = 6'b000011;
  localparam logic [5:0] ALU_XOR  = 6'b000100;
  localparam logic [5:0] ALU_SRL  = 6'b000101;
  localparam logic [5:0] ALU_OR   = 6'b000110;
  localparam logic [5:0] ALU_AND  = 6'b000111;
  localparam logic [5:0] ALU_SUB  = 6'b001000;
  localparam logic [5:0] ALU_SRA  = 6'b001101;
  localparam logic [5:0] ALU_EQ   = 6'b011000;
  localparam logic [5:0] ALU_NE   = 6'b011001;
  localparam logic [5:0] ALU_LTS  = 6'b011100;
  localparam logic [5:0] ALU_GES  = 6'b011101;
  localparam logic [5:0] ALU_LTU  = 6'b011110;
  localparam logic [5:0] ALU_GEU  = 6'b011111;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [1:0]      op_a;
    logic [2:0]      op_b;
    logic [5:0]      alu;
    logic            mem_req;
    logic            mem_we;
    logic [2:0]      mem_size;
    logic            gpr_we;
    logic            wb_src;
    logic            branch;
    logic            jal;
    logic            jalr;
    logic            illegal;
  } entry_t;

  // Safe, legal-encoded entry used at reset
  function automatic entry_t f_reset_entry();
    entry_t e;
    e          = '0;
    e.op_a     = OP_A_RS1;
    e.op_b     = OP_B_RS2;
    e.alu      = ALU_ADD;
    e.mem_size = LDST_W;
    e.wb_src   = WB_EX_RESULT;
    return e;
  endfunction

  logic [4:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [1:0] w_op_a;
  logic [2:0] w_op_b;
  logic [5:0] w_alu;
  logic       w_req, w_we, w_gwe, w_wb, w_br, w_jal, w_jalr, w_ill;
  logic [2:0] w_size;
  entry_t     w_entry;
  entry_t     w_head;
  logic       w_push, w_pop;
  logic [1:0] w_count_next;

  entry_t           r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             r_ready;
  logic [CNT_W-1:0] r_cnt;

  assign w_opcode = instr_i[6:2];
  assign w_funct3 = instr_i[14:12];
  assign w_funct7 = instr_i[31:25];

  // Combinational decode of the offered instruction into control fields
  always_comb begin
    w_op_a = OP_A_RS1;
    w_op_b = OP_B_RS2;
    w_alu  = ALU_ADD;
    w_req  = 1'b0;
    w_we   = 1'b0;
    w_size = LDST_W;
    w_gwe  = 1'b0;
    w_wb   = WB_EX_RESULT;
    w_br   = 1'b0;
    w_jal  = 1'b0;
    w_jalr = 1'b0;
    w_ill  = 1'b0;
    if (instr_i[1:0] != 2'b11) begin
      w_ill = 1'b1;
    end else begin
      case (w_opcode)
        OPC_LOAD: begin
          w_op_b = OP_B_IMM_I;
          w_req  = 1'b1;
          w_gwe  = 1'b1;
          w_wb   = WB_LSU_DATA;
          w_size = w_funct3;
          case (w_funct3)
            3'd0, 3'd1, 3'd2, 3'd4, 3'd5: w_ill = 1'b0;
            default:                      w_ill = 1'b1;
          endcase
        end
        OPC_STORE: begin
          w_op_b = OP_B_IMM_S;
          w_req  = 1'b1;
          w_we   = 1'b1;
          w_size = w_funct3;
          case (w_funct3)
            3'd0, 3'd1, 3'd2: w_ill = 1'b0;
            default:          w_ill = 1'b1;
          endcase
        end
        OPC_OP: begin
          w_gwe = 1'b1;
          case (w_funct7)
            7'h00: begin
              case (w_funct3)
                3'd0:    w_alu = ALU_ADD;
                3'd1:    w_alu = ALU_SLL;
                3'd2:    w_alu = ALU_SLTS;
                3'd3:    w_alu = ALU_SLTU;
                3'd4:    w_alu = ALU_XOR;
                3'd5:    w_alu = ALU_SRL;
                3'd6:    w_alu = ALU_OR;
                3'd7:    w_alu = ALU_AND;
                default: w_ill = 1'b1;
              endcase
            end
            7'h20: begin
              case (w_funct3)
                3'd0:    w_alu = ALU_SUB;
                3'd5:    w_alu = ALU_SRA;
                default: w_ill = 1'b1;
              endcase
            end
            7'h01: begin
              if (M_EXT) begin
                w_alu = {3'b100, w_funct3};
              end else begin
                w_ill = 1'b1;
              end
            end
            default: w_ill = 1'b1;
          endcase
        end
        OPC_OP_IMM: begin
          w_op_b = OP_B_IMM_I;
          w_gwe  = 1'b1;
          case (w_funct3)
            3'd0: w_alu = ALU_ADD;
            3'd2: w_alu = ALU_SLTS;
            3'd3: w_alu = ALU_SLTU;
            3'd4: w_alu = ALU_XOR;
            3'd6: w_alu = ALU_OR;
            3'd7: w_alu = ALU_AND;
            3'd1: begin
              w_alu = ALU_SLL;
              w_ill = (w_funct7 != 7'h00);
            end
            3'd5: begin
              w_alu = (w_funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
              w_ill = (w_funct7 != 7'h00) && (w_funct7 != 7'h20);
            end
            default: w_ill = 1'b1;
          endcase
        end
        OPC_LUI: begin
          w_op_a = OP_A_ZERO;
          w_op_b = OP_B_IMM_U;
          w_gwe  = 1'b1;
        end
        OPC_AUIPC: begin
          w_op_a = OP_A_CURR_PC;
          w_op_b = OP_B_IMM_U;
          w_gwe  = 1'b1;
        end
        OPC_BRANCH: begin
          w_br = 1'b1;
          case (w_funct3)
            3'd0:    w_alu = ALU_EQ;
            3'd1:    w_alu = ALU_NE;
            3'd4:    w_alu = ALU_LTS;
            3'd5:    w_alu = ALU_GES;
            3'd6:    w_alu = ALU_LTU;
            3'd7:    w_alu = ALU_GEU;
            default: w_ill = 1'b1;
          endcase
        end
        OPC_JAL: begin
          w_op_a = OP_A_CURR_PC;
          w_op_b = OP_B_INCR;
          w_gwe  = 1'b1;
          w_jal  = 1'b1;
        end
        OPC_JALR: begin
          w_op_a = OP_A_CURR_PC;
          w_op_b = OP_B_INCR;
          w_gwe  = 1'b1;
          w_jalr = 1'b1;
          w_ill  = (w_funct3 != 3'd0);
        end
        OPC_MISC_MEM: begin
          w_ill = (w_funct3 != 3'd0);
        end
        OPC_SYSTEM: begin
          // ecall / ebreak pass through as no-ops, anything else traps
          w_ill = (instr_i != 32'h0000_0073) && (instr_i != 32'h0010_0073);
        end
        default: w_ill = 1'b1;
      endcase
    end
  end

  // Assemble the FIFO entry; illegal instructions collapse to safe defaults
  always_comb begin
    w_entry     = f_reset_entry();
    w_entry.pc  = pc_i;
    w_entry.rs1 = instr_i[19:15];
    w_entry.rs2 = instr_i[24:20];
    w_entry.rd  = instr_i[11:7];
    if (w_ill) begin
      w_entry.illegal = 1'b1;
    end else begin
      w_entry.op_a     = w_op_a;
      w_entry.op_b     = w_op_b;
      w_entry.alu      = w_alu;
      w_entry.mem_req  = w_req;
      w_entry.mem_we   = w_we;
      w_entry.mem_size = w_size;
      w_entry.gpr_we   = w_gwe;
      w_entry.wb_src   = w_wb;
      w_entry.branch   = w_br;
      w_entry.jal      = w_jal;
      w_entry.jalr     = w_jalr;
      w_entry.illegal  = 1'b0;
    end
  end

  assign w_push = instr_valid_i & r_ready & ~flush_i;
  assign w_pop  = (r_count != 2'd0) & dec_ready_i;

  // Next occupancy; flush wins over push and pop
  always_comb begin
    if (flush_i) begin
      w_count_next = 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + 2'd1;
        2'b01:   w_count_next = r_count - 2'd1;
        default: w_count_next = r_count;
      endcase
    end
  end

  // FIFO storage write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mem[0] <= f_reset_entry();
      r_mem[1] <= f_reset_entry();
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // FIFO pointers, occupancy and the registered ready (never depends on dec_ready_i combinationally)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_ready  <= 1'b1;
    end else begin
      if (flush_i) begin
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
      end else begin
        r_wr_ptr <= r_wr_ptr ^ w_push;
        r_rd_ptr <= r_rd_ptr ^ w_pop;
      end
      r_count <= w_count_next;
      r_ready <= (w_count_next != 2'd2);
    end
  end

  // Saturating count of accepted illegal instructions; survives flush
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_push && w_entry.illegal && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign w_head          = r_mem[r_rd_ptr];
  assign instr_ready_o   = r_ready;
  assign dec_valid_o     = (r_count != 2'd0);
  assign dec_pc_o        = w_head.pc;
  assign rs1_o           = w_head.rs1;
  assign rs2_o           = w_head.rs2;
  assign rd_o            = w_head.rd;
  assign ex_op_a_sel_o   = w_head.op_a;
  assign ex_op_b_sel_o   = w_head.op_b;
  assign alu_op_o        = w_head.alu;
  assign mem_req_o       = w_head.mem_req;
  assign mem_we_o        = w_head.mem_we;
  assign mem_size_o      = w_head.mem_size;
  assign gpr_we_a_o      = w_head.gpr_we;
  assign wb_src_sel_o    = w_head.wb_src;
  assign branch_o        = w_head.branch;
  assign jal_o           = w_head.jal;
  assign jalr_o          = w_head.jalr;
  assign illegal_instr_o = w_head.illegal;
  assign illegal_cnt_o   = r_cnt;

endmodule

// File: tb/tb_miriscv_decode_stage.sv
// Bench for miriscv_decode_stage: one M_EXT=1 instance and one M_EXT=0/CNT_W=2
// instance share stimulus; expected head entries are queued on push, compared on pop.
module tb_miriscv_decode_stage;

  localparam int HW = 69;

  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_MUL = 6'b100000;
  localparam logic [1:0] A_RS1 = 2'd0;
  localparam logic [1:0] A_PC  = 2'd1;
  localparam logic [2:0] B_RS2 = 3'd0;
  localparam logic [2:0] B_II  = 3'd1;
  localparam logic [2:0] B_IS  = 3'd3;
  localparam logic [2:0] B_INC = 3'd4;
  localparam logic [2:0] SZ_W  = 3'd2;

  localparam logic [31:0] I_ADDI1 = 32'h0050_0093;
  localparam logic [31:0] I_ADDI2 = 32'h0060_0113;
  localparam logic [31:0] I_ADDI3 = 32'h0070_0193;
  localparam logic [31:0] I_SW    = 32'h0020_A423;
  localparam logic [31:0] I_MUL   = 32'h0220_81B3;
  localparam logic [31:0] I_JAL   = 32'h0080_00EF;
  localparam logic [31:0] I_ZERO  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] instr = 32'd0;
  logic [31:0] pc = 32'd0;
  logic        ivalid = 1'b0;
  logic        dready = 1'b0;

  logic a_ready, a_valid, a_req, a_we, a_gwe, a_wb, a_br, a_jal, a_jalr, a_ill;
  logic [31:0] a_pc;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [1:0]  a_opa;
  logic [2:0]  a_opb, a_size;
  logic [5:0]  a_alu;
  logic [7:0]  a_cnt;

  logic b_ready, b_valid, b_req, b_we, b_gwe, b_wb, b_br, b_jal, b_jalr, b_ill;
  logic [31:0] b_pc;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [1:0]  b_opa;
  logic [2:0]  b_opb, b_size;
  logic [5:0]  b_alu;
  logic [1:0]  b_cnt;

  logic [HW-1:0] a_head, b_head, exp_v;
  logic [HW-1:0] qa[$];
  logic [HW-1:0] qb[$];
  int vectors = 0;
  int miscompares = 0;

  assign a_head = {a_pc, a_rs1, a_rs2, a_rd, a_opa, a_opb, a_alu, a_req, a_we, a_size,
                   a_gwe, a_wb, a_br, a_jal, a_jalr, a_ill};
  assign b_head = {b_pc, b_rs1, b_rs2, b_rd, b_opa, b_opb, b_alu, b_req, b_we, b_size,
                   b_gwe, b_wb, b_br, b_jal, b_jalr, b_ill};

  miriscv_decode_stage #(.M_EXT(1'b1), .CNT_W(8), .PC_W(32)) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .instr_i(instr), .pc_i(pc),
    .instr_valid_i(ivalid), .instr_ready_o(a_ready), .dec_valid_o(a_valid),
    .dec_ready_i(dready), .dec_pc_o(a_pc), .rs1_o(a_rs1), .rs2_o(a_rs2), .rd_o(a_rd),
    .ex_op_a_sel_o(a_opa), .ex_op_b_sel_o(a_opb), .alu_op_o(a_alu),
    .mem_req_o(a_req), .mem_we_o(a_we), .mem_size_o(a_size), .gpr_we_a_o(a_gwe),
    .wb_src_sel_o(a_wb), .branch_o(a_br), .jal_o(a_jal), .jalr_o(a_jalr),
    .illegal_instr_o(a_ill), .illegal_cnt_o(a_cnt));

  miriscv_decode_stage #(.M_EXT(1'b0), .CNT_W(2), .PC_W(32)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .instr_i(instr), .pc_i(pc),
    .instr_valid_i(ivalid), .instr_ready_o(b_ready), .dec_valid_o(b_valid),
    .dec_ready_i(dready), .dec_pc_o(b_pc), .rs1_o(b_rs1), .rs2_o(b_rs2), .rd_o(b_rd),
    .ex_op_a_sel_o(b_opa), .ex_op_b_sel_o(b_opb), .alu_op_o(b_alu),
    .mem_req_o(b_req), .mem_we_o(b_we), .mem_size_o(b_size), .gpr_we_a_o(b_gwe),
    .wb_src_sel_o(b_wb), .branch_o(b_br), .jal_o(b_jal), .jalr_o(b_jalr),
    .illegal_instr_o(b_ill), .illegal_cnt_o(b_cnt));

  always #5 clk = ~clk;

  function automatic logic [HW-1:0] ev(input logic [31:0] p, input logic [4:0] r1, r2, d,
      input logic [1:0] oa, input logic [2:0] ob, input logic [5:0] alu,
      input logic req, we, input logic [2:0] sz, input logic gwe, wb, br, jl, jr, il);
    return {p, r1, r2, d, oa, ob, alu, req, we, sz, gwe, wb, br, jl, jr, il};
  endfunction

  // Illegal entry: register fields from the raw word, controls at safe defaults
  function automatic logic [HW-1:0] ev_ill(input logic [31:0] p, input logic [31:0] w);
    return ev(p, w[19:15], w[24:20], w[11:7], A_RS1, B_RS2, ALU_ADD,
              1'b0, 1'b0, SZ_W, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; ivalid = 1'b0; dready = 1'b0;
    instr = 32'd0; pc = 32'd0;
    step(); step();
    rst = 1'b0;
    qa.delete(); qb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    exp_v = ev(32'd0, 5'd0, 5'd0, 5'd0, A_RS1, B_RS2, ALU_ADD, 1'b0, 1'b0, SZ_W,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({a_valid, a_ready, a_cnt} !== {1'b0, 1'b1, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_ctl: got valid/ready/cnt %b/%b/%0d want 0/1/0", a_valid, a_ready, a_cnt);
    end
    vectors++;
    if (a_head !== exp_v) begin
      miscompares++;
      $display("FAIL reset_head: got %h want %h", a_head, exp_v);
    end
  endtask

  // addi, sw, mul, jal one at a time; mul is legal in dut_a, illegal in dut_b
  task automatic test_decode();
    logic [31:0] ti [4];
    ti[0] = I_ADDI1; ti[1] = I_SW; ti[2] = I_MUL; ti[3] = I_JAL;
    do_reset();
    dready = 1'b1;
    qa.push_back(ev(32'h100, 5'd0, 5'd5, 5'd1, A_RS1, B_II, ALU_ADD, 1'b0, 1'b0, SZ_W,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    qa.push_back(ev(32'h104, 5'd1, 5'd2, 5'd8, A_RS1, B_IS, ALU_ADD, 1'b1, 1'b1, SZ_W,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    qa.push_back(ev(32'h108, 5'd1, 5'd2, 5'd3, A_RS1, B_RS2, ALU_MUL, 1'b0, 1'b0, SZ_W,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    qa.push_back(ev(32'h10C, 5'd0, 5'd8, 5'd1, A_PC, B_INC, ALU_ADD, 1'b0, 1'b0, SZ_W,
                    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    qb.push_back(qa[0]);
    qb.push_back(qa[1]);
    qb.push_back(ev_ill(32'h108, I_MUL));
    qb.push_back(qa[3]);
    for (int i = 0; i < 4; i++) begin
      instr = ti[i]; pc = 32'h100 + 32'(4 * i); ivalid = 1'b1;
      step();
      ivalid = 1'b0;
      vectors++;
      if (!(a_valid === 1'b1 && b_valid === 1'b1)) begin
        miscompares++;
        $display("FAIL decode_valid[%0d]: got %b/%b want 1/1", i, a_valid, b_valid);
      end
      exp_v = qa.pop_front();
      vectors++;
      if (a_head !== exp_v) begin
        miscompares++;
        $display("FAIL decode_a[%0d]: got %h want %h", i, a_head, exp_v);
      end
      exp_v = qb.pop_front();
      vectors++;
      if (b_head !== exp_v) begin
        miscompares++;
        $display("FAIL decode_b[%0d]: got %h want %h", i, b_head, exp_v);
      end
      step();
    end
    vectors++;
    if ({a_valid, a_cnt, b_cnt} !== {1'b0, 8'd0, 2'd1}) begin
      miscompares++;
      $display("FAIL decode_cnt: got valid %b cnt_a %0d cnt_b %0d want 0 0 1", a_valid, a_cnt, b_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    dready = 1'b0;
    instr = I_ADDI1; pc = 32'h200; ivalid = 1'b1;
    qa.push_back(ev(32'h200, 5'd0, 5'd5, 5'd1, A_RS1, B_II, ALU_ADD, 1'b0, 1'b0, SZ_W,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    step();
    instr = I_ADDI2; pc = 32'h204;
    qa.push_back(ev(32'h204, 5'd0, 5'd6, 5'd2, A_RS1, B_II, ALU_ADD, 1'b0, 1'b0, SZ_W,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    step();
    instr = I_ADDI3; pc = 32'h208;
    for (int c = 0; c < 2; c++) begin
      vectors++;
      if (a_ready !== 1'b0 || a_head !== qa[0]) begin
        miscompares++;
        $display("FAIL b2b_full[%0d]: got ready %b head %h want 0 %h", c, a_ready, a_head, qa[0]);
      end
      step();
    end
    dready = 1'b1;
    for (int c = 0; c < 12 && (qa.size() > 0 || ivalid); c++) begin
      if (a_valid && qa.size() > 0) begin
        exp_v = qa.pop_front();
        vectors++;
        if (a_head !== exp_v) begin
          miscompares++;
          $display("FAIL b2b_order: got %h want %h", a_head, exp_v);
        end
      end
      if (ivalid && a_ready) begin
        qa.push_back(ev(32'h208, 5'd0, 5'd7, 5'd3, A_RS1, B_II, ALU_ADD, 1'b0, 1'b0, SZ_W,
                        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step();
        ivalid = 1'b0;
      end else begin
        step();
      end
    end
    vectors++;
    if (qa.size() != 0 || ivalid || a_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain: got %0d left valid %b want 0 0", qa.size(), a_valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    dready = 1'b0;
    instr = I_SW; pc = 32'h300; ivalid = 1'b1;
    step();
    instr = I_ADDI1; pc = 32'h304;
    step();
    vectors++;
    if (a_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_prefull: got ready %b want 0", a_ready);
    end
    flush = 1'b1; instr = I_MUL; pc = 32'h308;
    step();
    flush = 1'b0; ivalid = 1'b0;
    vectors++;
    if ({a_valid, a_ready, b_valid, b_cnt} !== {1'b0, 1'b1, 1'b0, 2'd0}) begin
      miscompares++;
      $display("FAIL flush_empty: got valid/ready/b_valid/b_cnt %b/%b/%b/%0d want 0/1/0/0",
               a_valid, a_ready, b_valid, b_cnt);
    end
    step(); step();
    vectors++;
    if (a_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_dropped: got valid %b want 0", a_valid);
    end
    dready = 1'b1; instr = I_ADDI2; pc = 32'h30C; ivalid = 1'b1;
    qa.push_back(ev(32'h30C, 5'd0, 5'd6, 5'd2, A_RS1, B_II, ALU_ADD, 1'b0, 1'b0, SZ_W,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    step();
    ivalid = 1'b0;
    exp_v = qa.pop_front();
    vectors++;
    if (a_valid !== 1'b1 || a_head !== exp_v) begin
      miscompares++;
      $display("FAIL flush_after: got valid %b head %h want 1 %h", a_valid, a_head, exp_v);
    end
    step();
  endtask

  task automatic test_illegal_saturation();
    do_reset();
    dready = 1'b1; instr = I_ZERO; ivalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      pc = 32'h400 + 32'(4 * k);
      vectors++;
      if (a_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL sat_ready[%0d]: got %b want 1", k, a_ready);
      end
      qb.push_back(ev_ill(pc, I_ZERO));
      step();
      vectors++;
      if (b_cnt !== ((k < 2) ? 2'(k + 1) : 2'd3) || a_cnt !== 8'(k + 1)) begin
        miscompares++;
        $display("FAIL sat_cnt[%0d]: got b %0d a %0d want b %0d a %0d", k, b_cnt, a_cnt,
                 (k < 2) ? k + 1 : 3, k + 1);
      end
      if (b_valid && qb.size() > 0) begin
        exp_v = qb.pop_front();
        vectors++;
        if (b_head !== exp_v) begin
          miscompares++;
          $display("FAIL sat_head[%0d]: got %h want %h", k, b_head, exp_v);
        end
      end
    end
    ivalid = 1'b0;
    step();
  endtask

  task automatic test_reset_midop();
    do_reset();
    dready = 1'b0;
    instr = I_ZERO; pc = 32'h500; ivalid = 1'b1;
    step();
    instr = I_SW; pc = 32'h504;
    step();
    vectors++;
    if (a_cnt !== 8'd1 || a_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_pre: got cnt %0d ready %b want 1 0", a_cnt, a_ready);
    end
    rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; ivalid = 1'b0;
    exp_v = ev(32'd0, 5'd0, 5'd0, 5'd0, A_RS1, B_RS2, ALU_ADD, 1'b0, 1'b0, SZ_W,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({a_valid, a_ready, a_cnt} !== {1'b0, 1'b1, 8'd0} || a_head !== exp_v) begin
      miscompares++;
      $display("FAIL midop_reset: got %b/%b/%0d head %h want 0/1/0 head %h",
               a_valid, a_ready, a_cnt, a_head, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_illegal_saturation();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
